// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU with an iterative multiply/divide unit and HI/LO registers.
// Single-cycle ops are combinational; MULT/DIV occupy the unit for WIDTH cycles.
module alu_mdu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             flush,
    input  logic [4:0]       ALUControl,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic [WIDTH-1:0] C,
    output logic             zero,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_XOR  = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_SRA  = 5'b01000;
    localparam logic [4:0] OP_BEQ  = 5'b01001;
    localparam logic [4:0] OP_BNE  = 5'b01010;
    localparam logic [4:0] OP_NOR  = 5'b01100;
    localparam logic [4:0] OP_SLTU = 5'b11000;
    localparam logic [4:0] OP_MFHI = 5'b10100;
    localparam logic [4:0] OP_MFLO = 5'b10101;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic is_div;
        logic neg_q;   // negate product / quotient at the end
        logic neg_r;   // negate remainder (dividend was negative)
        logic div0;
    } mdu_op_t;

    state_t           state, state_nxt;
    mdu_op_t          op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, shreg, opnd, dividend;

    logic [SHAMT_W-1:0] shamt;
    assign shamt = Ain[SHAMT_W-1:0];

    always_comb begin
        C    = '0;
        zero = 1'b0;
        case (ALUControl)
            OP_AND:  C = Ain & Bin;
            OP_OR:   C = Ain | Bin;
            OP_ADD:  C = Ain + Bin;
            OP_SUB:  C = Ain - Bin;
            OP_XOR:  C = Ain ^ Bin;
            OP_NOR:  C = ~(Ain | Bin);
            OP_SLT:  C = {{(WIDTH-1){1'b0}}, $signed(Ain) < $signed(Bin)};
            OP_SLTU: C = {{(WIDTH-1){1'b0}}, Ain < Bin};
            OP_SLL:  C = Bin << shamt;
            OP_SRL:  C = Bin >> shamt;
            OP_SRA:  C = WIDTH'($signed(Bin) >>> shamt);
            OP_BEQ: begin
                C    = {{(WIDTH-1){1'b0}}, Ain == Bin};
                zero = (Ain == Bin);
            end
            OP_BNE: begin
                C    = {{(WIDTH-1){1'b0}}, Ain != Bin};
                zero = (Ain != Bin);
            end
            OP_MFHI: C = hi;
            OP_MFLO: C = lo;
            default: C = '0;
        endcase
    end

    // 10xxx is the whole MDU group: mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
    logic is_mdu, is_muldiv, is_mt, start, mt_wr, finish;
    assign is_mdu    = (ALUControl[4:3] == 2'b10);
    assign is_muldiv = is_mdu & ~ALUControl[2];
    assign is_mt     = is_mdu & ALUControl[2] & ALUControl[1];
    assign busy      = (state == RUN);
    assign stall     = in_valid & busy & is_mdu;
    assign start     = in_valid & is_muldiv & (state == IDLE) & ~flush;
    assign mt_wr     = in_valid & is_mt & ~busy & ~flush;
    assign finish    = busy & ~flush & (cnt == CNT_W'(1));

    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign sgn   = ~ALUControl[0];
    assign a_neg = sgn & Ain[WIDTH-1];
    assign b_neg = sgn & Bin[WIDTH-1];
    assign a_mag = a_neg ? -Ain : Ain;
    assign b_mag = b_neg ? -Bin : Bin;

    // One iteration: shift-add for mult, restoring subtract for div.
    logic [WIDTH:0]     sum, rem_try, diff;
    logic [WIDTH-1:0]   acc_nxt, shreg_nxt, hi_res, lo_res;
    logic [2*WIDTH-1:0] prod;
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, opnd & {WIDTH{shreg[0]}}};
        rem_try = {acc, shreg[WIDTH-1]};
        diff    = rem_try - {1'b0, opnd};
        if (op_q.is_div) begin
            acc_nxt   = diff[WIDTH] ? rem_try[WIDTH-1:0] : diff[WIDTH-1:0];
            shreg_nxt = {shreg[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            acc_nxt   = sum[WIDTH:1];
            shreg_nxt = {sum[0], shreg[WIDTH-1:1]};
        end
        prod = {acc_nxt, shreg_nxt};
        if (op_q.neg_q)
            prod = -prod;
        if (!op_q.is_div) begin
            hi_res = prod[2*WIDTH-1:WIDTH];
            lo_res = prod[WIDTH-1:0];
        end else if (op_q.div0) begin
            hi_res = dividend;
            lo_res = '1;
        end else begin
            hi_res = op_q.neg_r ? -acc_nxt : acc_nxt;
            lo_res = op_q.neg_q ? -shreg_nxt : shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (flush || cnt == CNT_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            cnt      <= '0;
            acc      <= '0;
            shreg    <= '0;
            opnd     <= '0;
            dividend <= '0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state <= state_nxt;
            done  <= finish;
            if (start) begin
                cnt         <= CNT_W'(WIDTH);
                acc         <= '0;
                shreg       <= a_mag;
                opnd        <= b_mag;
                dividend    <= Ain;
                op_q.is_div <= ALUControl[1];
                op_q.neg_q  <= a_neg ^ b_neg;
                op_q.neg_r  <= a_neg;
                op_q.div0   <= ~|Bin;
            end else if (busy) begin
                cnt   <= cnt - CNT_W'(1);
                acc   <= acc_nxt;
                shreg <= shreg_nxt;
            end
            if (finish) begin
                hi <= hi_res;
                lo <= lo_res;
            end else if (mt_wr) begin
                if (ALUControl[0]) lo <= Ain;
                else               hi <= Ain;
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed + randomized checks of alu_mdu against an arithmetic reference model.
// A 32-bit instance carries most of the checks; a 16-bit instance covers parametrisation.
module tb_alu_mdu;
    localparam logic [4:0] ADD = 5'b00010, SRA = 5'b01000, BEQ = 5'b01001, BNE = 5'b01010;
    localparam logic [4:0] SLTU = 5'b11000, MULT = 5'b10000, MULTU = 5'b10001;
    localparam logic [4:0] DIV = 5'b10010, DIVU = 5'b10011, MFHI = 5'b10100, MFLO = 5'b10101;
    localparam logic [4:0] MTHI = 5'b10110, MTLO = 5'b10111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, flush;
    logic [4:0]  op;
    logic [31:0] a, b, c, hi, lo;
    logic        zero, stall, busy, done;

    logic        iv16, fl16;
    logic [4:0]  op16;
    logic [15:0] a16, b16, c16, hi16, lo16;
    logic        zero16, stall16, busy16, done16;

    alu_mdu #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .ALUControl(op),
        .Ain(a), .Bin(b), .C(c), .zero(zero), .stall(stall), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    alu_mdu #(.WIDTH(16), .SHAMT_W(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .flush(fl16), .ALUControl(op16),
        .Ain(a16), .Bin(b16), .C(c16), .zero(zero16), .stall(stall16), .busy(busy16),
        .done(done16), .hi(hi16), .lo(lo16)
    );

    int n_chk = 0, n_pass = 0;
    logic [31:0] mhi = '0, mlo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU from the opcode table.
    task automatic ref_alu(input logic [4:0] o, input logic [31:0] x, y, h, l,
                           output logic [31:0] r, output logic z);
        int sh;
        sh = int'(x[4:0]);
        z  = 1'b0;
        case (o)
            5'd0:  r = x & y;
            5'd1:  r = x | y;
            5'd2:  r = x + y;
            5'd3:  r = x ^ y;
            5'd4:  r = y << sh;
            5'd5:  r = y >> sh;
            5'd6:  r = x - y;
            5'd7:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            5'd8: begin
                r = y >> sh;
                if (y[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            5'd9:  begin r = (x == y) ? 32'd1 : 32'd0; z = (x == y); end
            5'd10: begin r = (x != y) ? 32'd1 : 32'd0; z = (x != y); end
            5'd12: r = ~(x | y);
            5'd24: r = (x < y) ? 32'd1 : 32'd0;
            5'd20: r = h;
            5'd21: r = l;
            default: r = 32'd0;
        endcase
    endtask

    // Reference MDU: returns {hi, lo}.
    function automatic logic [63:0] ref_mdu(input logic [4:0] o, input logic [31:0] x, y);
        longint sx, sy, q, r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o[1] && y == 32'd0) return {x, 32'hFFFF_FFFF};
        case (o)
            MULT:  res = 64'(sx * sy);
            MULTU: res = {32'd0, x} * {32'd0, y};
            DIV: begin
                q = sx / sy;
                r = sx % sy;
                res = {r[31:0], q[31:0]};
            end
            default: res = {x % y, x / y};
        endcase
        return res;
    endfunction

    task automatic run_mdu(input logic [4:0] o, input logic [31:0] x, y, input string tag);
        logic [63:0] exp;
        int n;
        exp = ref_mdu(o, x, y);
        in_valid = 1'b1; op = o; a = x; b = y;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk({tag, ".cycles"}, 64'(n), 64'd32);
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".hilo"}, {hi, lo}, exp);
        mhi = exp[63:32];
        mlo = exp[31:0];
        tick();
        chk({tag, ".done_clr"}, 64'(done), 64'd0);
    endtask

    logic [4:0] alu_ops [19] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd24, 5'd20, 5'd21};
    logic [4:0] mdu_ops [4] = '{MULT, MULTU, DIV, DIVU};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad;
        logic [31:0] ec, x, y;
        logic ez;
        logic [15:0] p, q;

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        iv16 = 1'b0; fl16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        tick(); tick();
        chk("rst.hilo", {hi, lo}, 64'd0);
        chk("rst.busy_done", {62'd0, busy, done}, 64'd0);
        chk("rst16.hilo", {32'd0, hi16, lo16}, 64'd0);
        rst = 1'b0;

        // Directed single-cycle ops
        in_valid = 1'b1;
        op = ADD; a = 32'd7; b = 32'hFFFF_FFFD; #1;
        chk("add", {31'd0, zero, c}, {31'd0, 1'b0, 32'd4});
        op = BEQ; a = 32'd5; b = 32'd5; #1;
        chk("beq", {31'd0, zero, c}, {31'd0, 1'b1, 32'd1});
        op = BNE; #1;
        chk("bne", {31'd0, zero, c}, {31'd0, 1'b0, 32'd0});
        op = SRA; a = 32'd36; b = 32'h8000_0000; #1;
        chk("sra", 64'(c), 64'hF800_0000);
        op = SLTU; a = 32'd1; b = 32'hFFFF_FFFF; #1;
        chk("sltu", 64'(c), 64'd1);
        op = MFLO; #1;
        chk("idle_nostall", 64'(stall), 64'd0);
        in_valid = 1'b0;
        tick();

        // Directed MDU ops
        run_mdu(MULT,  32'hFFFF_FFFD, 32'd5, "mult");
        run_mdu(MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
        chk("multu.const", {hi, lo}, {32'd1, 32'hFFFF_FFFE});
        run_mdu(DIV,   32'hFFFF_FFF9, 32'd2, "div");
        chk("div.const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_mdu(DIVU,  32'd100, 32'd0, "divu0");
        chk("divu0.const", {hi, lo}, {32'h64, 32'hFFFF_FFFF});
        run_mdu(DIV,   32'h8000_0000, 32'hFFFF_FFFF, "divmin");
        chk("divmin.const", {hi, lo}, {32'd0, 32'h8000_0000});
        run_mdu(DIV,   32'hFFFF_FFFB, 32'd0, "divneg0");

        // Random single-cycle ops (mfhi/mflo see the model's hi/lo)
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op = alu_ops[$urandom_range(0, 18)];
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            #1;
            ref_alu(op, a, b, mhi, mlo, ec, ez);
            chk("alu_rand", {31'd0, zero, c}, {31'd0, ez, ec});
        end
        in_valid = 1'b0;
        tick();

        // Random MDU ops with occasional zero / -1 / MIN operands
        for (int i = 0; i < 12; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: x = 32'h8000_0000;
                3: y = $urandom_range(1, 15);
                default: ;
            endcase
            run_mdu(mdu_ops[$urandom_range(0, 3)], x, y, "mdu_rand");
        end

        // Stall behaviour while a mult runs
        in_valid = 1'b1; op = MULT; a = 32'hFFFF_FFFD; b = 32'd5;
        tick();
        op = ADD; a = 32'd10; b = 32'd20; #1;
        chk("busy_add.stall", 64'(stall), 64'd0);
        chk("busy_add.c", 64'(c), 64'd30);
        tick();
        op = MTHI; a = 32'hDEAD_BEEF; #1;
        chk("busy_mthi.stall", 64'(stall), 64'd1);
        tick();
        op = MFLO;
        n = 2; bad = 0;
        while (busy === 1'b1 && n < 100) begin
            if (stall !== 1'b1) bad++;
            n++;
            tick();
        end
        chk("stall.cycles", 64'(n), 64'd32);
        chk("stall.held", 64'(bad), 64'd0);
        chk("stall.released", 64'(stall), 64'd0);
        chk("stall.mflo", 64'(c), 64'hFFFF_FFF1);
        chk("stall.hi", 64'(hi), 64'hFFFF_FFFF);
        chk("stall.done", 64'(done), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("stall.done_clr", 64'(done), 64'd0);

        // mthi/mtlo, then flush mid-mult
        in_valid = 1'b1; op = MTHI; a = 32'h11; tick();
        op = MTLO; a = 32'h22; tick();
        chk("mt.hilo", {hi, lo}, {32'h11, 32'h22});
        op = MULT; a = $urandom; b = $urandom; tick();
        in_valid = 1'b0;
        repeat (9) tick();
        chk("flush.pre_busy", 64'(busy), 64'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush.busy", 64'(busy), 64'd0);
        chk("flush.hilo", {hi, lo}, {32'h11, 32'h22});
        chk("flush.nodone", 64'(done), 64'd0);
        tick();
        chk("flush.nodone2", 64'(done), 64'd0);
        in_valid = 1'b1; flush = 1'b1; op = MULT; tick();
        chk("flush.blocks_start", 64'(busy), 64'd0);
        op = MTHI; a = 32'h99; tick();
        chk("flush.blocks_mt", 64'(hi), 64'h11);
        flush = 1'b0; in_valid = 1'b0;

        // Reset in the middle of a divide
        in_valid = 1'b1; op = DIV; a = $urandom; b = 32'd3; tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_mid.busy", 64'(busy), 64'd0);
        chk("rst_mid.hilo", {hi, lo}, 64'd0);
        chk("rst_mid.done", 64'(done), 64'd0);

        // 16-bit instance
        iv16 = 1'b1; op16 = MULT; a16 = 16'h8000; b16 = 16'h8000; tick();
        iv16 = 1'b0;
        n = 0;
        while (busy16 === 1'b1 && n < 100) begin n++; tick(); end
        chk("w16.cycles", 64'(n), 64'd16);
        chk("w16.hilo", {32'd0, hi16, lo16}, {32'd0, 16'h4000, 16'h0000});
        chk("w16.done", 64'(done16), 64'd1);
        p = 16'($urandom); q = 16'($urandom);
        iv16 = 1'b1; op16 = MULTU; a16 = p; b16 = q; tick();
        iv16 = 1'b0;
        n = 0;
        while (busy16 === 1'b1 && n < 100) begin n++; tick(); end
        chk("w16u.cycles", 64'(n), 64'd16);
        chk("w16u.hilo", {32'd0, hi16, lo16}, {32'd0, {16'd0, p} * {16'd0, q}});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
